// File: rtl/burst_mem_responder_pkg.sv
// Shared constants, state encoding and beat-offset helper for the burst responder.
// No logic or latency of its own.
// No flow control of its own.
package burst_mem_responder_pkg;

    localparam int BEATS       = 4;
    localparam int BEAT_W      = 64;
    localparam int LINE_W      = 256;
    localparam int OFFSET_BITS = 5;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        BURST,
        DONE
    } state_e;

    // Bit offset of a beat inside a line; beat 0 occupies the low 64 bits.
    function automatic logic [7:0] beat_lsb(input logic [1:0] beat);
        return {beat, 6'd0};
    endfunction

endpackage

// File: rtl/burst_line_ram.sv
// Line store: 256-bit wide, 2**IDX_BITS deep, not touched by reset.
// Read is combinational; a write lands at the clock edge.
// No backpressure; every write strobe is honoured.
module burst_line_ram
    import burst_mem_responder_pkg::*;
#(
    parameter int IDX_BITS = 6
) (
    input  logic                clk,
    input  logic                we_i,
    input  logic [IDX_BITS-1:0] waddr_i,
    input  logic [LINE_W-1:0]   wdata_i,
    input  logic [IDX_BITS-1:0] raddr_i,
    output logic [LINE_W-1:0]   rdata_o
);

    localparam int DEPTH = 1 << IDX_BITS;

    logic [LINE_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/burst_mem_responder.sv
// Four-beat line read/write responder in front of a line RAM.
// First beat LATENCY cycles after acceptance, then 4 back-to-back beats.
// Initiator holds its request level; dropping it mid-transaction aborts.
module burst_mem_responder
    import burst_mem_responder_pkg::*;
#(
    parameter int LATENCY  = 4,
    parameter int IDX_BITS = 6
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [31:0]       address_i,
    input  logic              read_i,
    input  logic              write_i,
    input  logic [BEAT_W-1:0] burst_i,
    output logic [BEAT_W-1:0] burst_o,
    output logic              resp_o,
    output logic              err_o
);

    localparam logic [3:0] LAT_LOAD = 4'(LATENCY - 1);

    state_e              state_q;
    logic                op_wr_q;
    logic [IDX_BITS-1:0] idx_q;
    logic [3:0]          lat_q;
    logic [1:0]          beat_q;
    logic [1:0]          beat_d;
    logic [LINE_W-1:0]   stage_q;
    logic                resp_q;
    logic [BEAT_W-1:0]   burst_q;
    logic                err_q;

    logic                req_held;
    logic                ram_we;
    logic [LINE_W-1:0]   ram_wdata;
    logic [LINE_W-1:0]   rd_line;
    logic                unused_addr;

    assign unused_addr = ^{address_i[31:OFFSET_BITS+IDX_BITS], address_i[OFFSET_BITS-1:0]};

    // Only the level of the operation that was latched keeps the transaction alive.
    assign req_held = op_wr_q ? write_i : read_i;
    assign beat_d   = beat_q + 2'd1;

    // Beat 3 data is still on burst_i, so the commit merges it directly.
    assign ram_we    = (state_q == BURST) && op_wr_q && write_i && (beat_q == 2'(BEATS - 1));
    assign ram_wdata = {burst_i, stage_q[LINE_W-BEAT_W-1:0]};

    burst_line_ram #(
        .IDX_BITS (IDX_BITS)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i (idx_q),
        .wdata_i (ram_wdata),
        .raddr_i (idx_q),
        .rdata_o (rd_line)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            op_wr_q <= 1'b0;
            idx_q   <= '0;
            lat_q   <= '0;
            beat_q  <= '0;
            stage_q <= '0;
            resp_q  <= 1'b0;
            burst_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    resp_q  <= 1'b0;
                    burst_q <= '0;
                    if (read_i || write_i) begin
                        op_wr_q <= !read_i;
                        idx_q   <= address_i[OFFSET_BITS+IDX_BITS-1:OFFSET_BITS];
                        lat_q   <= LAT_LOAD;
                        beat_q  <= '0;
                        state_q <= WAIT;
                        if (read_i && write_i) begin
                            err_q <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (!req_held) begin
                        state_q <= IDLE;
                        lat_q   <= '0;
                        err_q   <= 1'b1;
                    end else if (lat_q == 4'd0) begin
                        state_q <= BURST;
                        beat_q  <= '0;
                        resp_q  <= 1'b1;
                        burst_q <= op_wr_q ? '0 : rd_line[BEAT_W-1:0];
                    end else begin
                        lat_q <= lat_q - 4'd1;
                    end
                end
                BURST: begin
                    if (!req_held) begin
                        state_q <= IDLE;
                        beat_q  <= '0;
                        resp_q  <= 1'b0;
                        burst_q <= '0;
                        err_q   <= 1'b1;
                    end else begin
                        if (op_wr_q) begin
                            stage_q[beat_lsb(beat_q) +: BEAT_W] <= burst_i;
                        end
                        if (beat_q == 2'(BEATS - 1)) begin
                            state_q <= DONE;
                            beat_q  <= '0;
                            resp_q  <= 1'b0;
                            burst_q <= '0;
                        end else begin
                            beat_q  <= beat_d;
                            burst_q <= op_wr_q ? '0 : rd_line[beat_lsb(beat_d) +: BEAT_W];
                        end
                    end
                end
                DONE: begin
                    resp_q  <= 1'b0;
                    burst_q <= '0;
                    if (!read_i && !write_i) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign resp_o  = resp_q;
    assign burst_o = burst_q;
    assign err_o   = err_q;

endmodule

// File: tb/tb_burst_mem_responder.sv
// Directed bench for burst_mem_responder: latency builds 1/4/15 share stimulus.
module tb_burst_mem_responder;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [31:0] address_i = '0;
    logic        read_i = 1'b0;
    logic        write_i = 1'b0;
    logic [63:0] burst_i = '0;
    logic [63:0] burst_o, burst_o_l1, burst_o_l15;
    logic        resp_o, resp_o_l1, resp_o_l15;
    logic        err_o, err_o_l1, err_o_l15;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    burst_mem_responder #(.LATENCY(4), .IDX_BITS(6)) dut (
        .clk(clk), .reset_n(reset_n), .address_i(address_i), .read_i(read_i),
        .write_i(write_i), .burst_i(burst_i), .burst_o(burst_o), .resp_o(resp_o), .err_o(err_o));

    burst_mem_responder #(.LATENCY(1), .IDX_BITS(6)) dut_l1 (
        .clk(clk), .reset_n(reset_n), .address_i(address_i), .read_i(read_i),
        .write_i(write_i), .burst_i(burst_i), .burst_o(burst_o_l1), .resp_o(resp_o_l1), .err_o(err_o_l1));

    burst_mem_responder #(.LATENCY(15), .IDX_BITS(6)) dut_l15 (
        .clk(clk), .reset_n(reset_n), .address_i(address_i), .read_i(read_i),
        .write_i(write_i), .burst_i(burst_i), .burst_o(burst_o_l15), .resp_o(resp_o_l15), .err_o(err_o_l15));

    // Entered just after a rising edge; returns just after a rising edge with the
    // request low for one full cycle so the next call is accepted from IDLE.
    task automatic do_txn(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [255:0] wline, input int stop_after, input int hold,
                          output int nresp, output logic [255:0] rline,
                          output int first_cyc, output int extra);
        int cyc;
        bit done;
        nresp = 0; rline = '0; first_cyc = -1; extra = 0; cyc = 0; done = 0;
        address_i = addr; read_i = rd; write_i = wr; burst_i = wline[63:0];
        @(posedge clk); #1;
        address_i = addr ^ 32'hFFFF_FFC0;
        while (!done && cyc < 40) begin
            @(negedge clk);
            if (resp_o) begin
                if (nresp == 0) first_cyc = cyc;
                if (nresp < 4) rline[64*nresp +: 64] = burst_o;
                nresp++;
            end
            @(posedge clk); cyc++; #1;
            if (nresp >= stop_after) done = 1;
            else burst_i = wline[64*nresp +: 64];
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (resp_o) extra++;
            @(posedge clk); #1;
        end
        read_i = 0; write_i = 0; burst_i = '0;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset_n = 0; read_i = 0; write_i = 0;
        @(posedge clk); #1;
        reset_n = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        #2;
        reset_n = 0; read_i = 1; write_i = 0; address_i = '0; burst_i = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++; if (resp_o !== 1'b0) begin bad++; $display("FAIL reset_resp cyc%0d got=%b want=0", i, resp_o); end
            total++; if (burst_o !== 64'd0) begin bad++; $display("FAIL reset_burst cyc%0d got=%h want=0", i, burst_o); end
            total++; if (err_o !== 1'b0) begin bad++; $display("FAIL reset_err cyc%0d got=%b want=0", i, err_o); end
        end
    endtask

    task automatic test_latency();
        int f4 = -1, f1 = -1, f15 = -1, l4 = 0, l1 = 0, l15 = 0, n4 = 0, n1 = 0, n15 = 0;
        @(posedge clk); #1;
        reset_n = 1;
        @(posedge clk);
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            if (resp_o)     begin if (f4 < 0) f4 = c;   l4 = c;  n4++;  end
            if (resp_o_l1)  begin if (f1 < 0) f1 = c;   l1 = c;  n1++;  end
            if (resp_o_l15) begin if (f15 < 0) f15 = c; l15 = c; n15++; end
            @(posedge clk);
        end
        #1 read_i = 0;
        @(posedge clk); #1;
        total++; if (f4 != 4)   begin bad++; $display("FAIL lat4_first got=%0d want=4", f4); end
        total++; if (f1 != 1)   begin bad++; $display("FAIL lat1_first got=%0d want=1", f1); end
        total++; if (f15 != 15) begin bad++; $display("FAIL lat15_first got=%0d want=15", f15); end
        total++; if (n4 != 4)   begin bad++; $display("FAIL lat4_beats got=%0d want=4", n4); end
        total++; if (n1 != 4)   begin bad++; $display("FAIL lat1_beats got=%0d want=4", n1); end
        total++; if (n15 != 4)  begin bad++; $display("FAIL lat15_beats got=%0d want=4", n15); end
        total++; if (l4 - f4 != 3)   begin bad++; $display("FAIL lat4_span got=%0d want=3", l4 - f4); end
        total++; if (l1 - f1 != 3)   begin bad++; $display("FAIL lat1_span got=%0d want=3", l1 - f1); end
        total++; if (l15 - f15 != 3) begin bad++; $display("FAIL lat15_span got=%0d want=3", l15 - f15); end
    endtask

    task automatic test_write_read();
        logic [255:0] w, r;
        int n, f, x;
        w = {{8{8'h44}}, {8{8'h33}}, {8{8'h22}}, {8{8'h11}}};
        do_txn(1'b0, 1'b1, 32'h0000_0040, w, 4, 0, n, r, f, x);
        total++; if (n != 4) begin bad++; $display("FAIL wr_beats got=%0d want=4", n); end
        total++; if (f != 4) begin bad++; $display("FAIL wr_latency got=%0d want=4", f); end
        do_txn(1'b1, 1'b0, 32'h0000_0040, '0, 4, 0, n, r, f, x);
        total++; if (n != 4) begin bad++; $display("FAIL rd_beats got=%0d want=4", n); end
        total++; if (r !== w) begin bad++; $display("FAIL rd_data got=%h want=%h", r, w); end
        @(negedge clk);
        total++; if (err_o !== 1'b0) begin bad++; $display("FAIL wr_rd_err got=%b want=0", err_o); end
        total++; if (resp_o !== 1'b0) begin bad++; $display("FAIL idle_resp got=%b want=0", resp_o); end
        @(posedge clk); #1;
    endtask

    task automatic test_both_high();
        logic [255:0] rl, sl, r;
        int n, f, x;
        rl = {64'hA3A3_0000_1111_C0C0, 64'hA2A2_2222_3333_C0C0, 64'hA1A1_4444_5555_C0C0, 64'hA0A0_6666_7777_C0C0};
        sl = {4{64'hBAD0_BAD0_BAD0_BAD0}};
        do_txn(1'b0, 1'b1, 32'h0000_00C0, rl, 4, 0, n, r, f, x);
        do_txn(1'b1, 1'b1, 32'h0000_00C0, sl, 4, 0, n, r, f, x);
        total++; if (n != 4) begin bad++; $display("FAIL both_beats got=%0d want=4", n); end
        total++; if (r !== rl) begin bad++; $display("FAIL both_rdata got=%h want=%h", r, rl); end
        @(negedge clk);
        total++; if (err_o !== 1'b1) begin bad++; $display("FAIL both_err got=%b want=1", err_o); end
        @(posedge clk); #1;
        do_txn(1'b1, 1'b0, 32'h0000_00C0, '0, 4, 0, n, r, f, x);
        total++; if (r !== rl) begin bad++; $display("FAIL both_storage got=%h want=%h", r, rl); end
    endtask

    task automatic test_reset_persist();
        logic [255:0] w, r;
        int n, f, x;
        w = {{8{8'h44}}, {8{8'h33}}, {8{8'h22}}, {8{8'h11}}};
        do_reset();
        @(negedge clk);
        total++; if (err_o !== 1'b0) begin bad++; $display("FAIL rst_err_clear got=%b want=0", err_o); end
        @(posedge clk); #1;
        do_txn(1'b1, 1'b0, 32'h0000_0040, '0, 4, 0, n, r, f, x);
        total++; if (r !== w) begin bad++; $display("FAIL rst_storage got=%h want=%h", r, w); end
    endtask

    task automatic test_abort();
        logic [255:0] p, q, r;
        int n, f, x;
        p = {64'h8003_8003_8003_8003, 64'h8002_8002_8002_8002, 64'h8001_8001_8001_8001, 64'h8000_8000_8000_8000};
        q = {4{64'hFFFF_0000_FFFF_0000}};
        do_txn(1'b0, 1'b1, 32'h0000_0080, p, 4, 0, n, r, f, x);
        do_txn(1'b0, 1'b1, 32'h0000_0080, q, 2, 0, n, r, f, x);
        total++; if (n != 2) begin bad++; $display("FAIL abort_beats got=%0d want=2", n); end
        @(negedge clk);
        total++; if (resp_o !== 1'b0) begin bad++; $display("FAIL abort_resp got=%b want=0", resp_o); end
        total++; if (err_o !== 1'b1) begin bad++; $display("FAIL abort_err got=%b want=1", err_o); end
        @(posedge clk); #1;
        do_txn(1'b1, 1'b0, 32'h0000_0080, '0, 4, 0, n, r, f, x);
        total++; if (r !== p) begin bad++; $display("FAIL abort_storage got=%h want=%h", r, p); end
    endtask

    task automatic test_done_hold();
        logic [255:0] w, r;
        int n, f, x;
        w = {{8{8'h44}}, {8{8'h33}}, {8{8'h22}}, {8{8'h11}}};
        do_txn(1'b1, 1'b0, 32'h0000_0040, '0, 4, 6, n, r, f, x);
        total++; if (n != 4) begin bad++; $display("FAIL hold_beats got=%0d want=4", n); end
        total++; if (x != 0) begin bad++; $display("FAIL hold_extra_resp got=%0d want=0", x); end
        total++; if (r !== w) begin bad++; $display("FAIL hold_rdata got=%h want=%h", r, w); end
        do_txn(1'b1, 1'b0, 32'h0000_0040, '0, 4, 0, n, r, f, x);
        total++; if (f != 4) begin bad++; $display("FAIL after_hold_latency got=%0d want=4", f); end
        total++; if (n != 4) begin bad++; $display("FAIL after_hold_beats got=%0d want=4", n); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_write_read();
        test_both_high();
        test_reset_persist();
        test_abort();
        test_done_hold();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
